buscador_sar: RTL and testbench

- Successive-approximation search engine: the driving end of the mayor/igual/menor comparator interface.
- Drives candidate operand `propuesta` into an external combinational N-bit magnitude comparator, whose other operand is an unknown `objetivo`.
- Consumes the mayor/igual/menor flags and converges on `objetivo` in at most N evaluation cycles, MSB first.
- Sits above the comparator blocks as the first sequential consumer of their flags.

---
 rtl/sar_pkg.sv | 12 +
 rtl/buscador_sar.sv | 93 +++++++++
 tb/tb_buscador_sar.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search engine.
package sar_pkg;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    EVALUAR = 2'd1,
    FIN     = 2'd2
  } estado_t;

  localparam int unsigned N_DEF = 8;

endpackage

// File: rtl/buscador_sar.sv
// Successive-approximation search: drives a candidate into an external
// magnitude comparator and resolves objetivo MSB first from its flags.
module buscador_sar
  import sar_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned W_IDX = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inicio,
  input  logic         mayor,
  input  logic         igual,
  input  logic         menor,
  output logic [N-1:0] propuesta,
  output logic         ocupado,
  output logic         listo,
  output logic [N-1:0] resultado,
  output logic         error
);

  estado_t          estado;
  logic [W_IDX-1:0] idx;
  logic [N-1:0]     bit_idx;
  logic [N-1:0]     bit_sig;
  logic [N-1:0]     cand;
  logic             flags_ok;

  always_comb begin
    bit_idx  = {{(N-1){1'b0}}, 1'b1} << idx;
    bit_sig  = bit_idx >> 1;
    cand     = menor ? (propuesta & ~bit_idx) : propuesta;
    // exactly one of the three flags asserted
    flags_ok = (mayor ^ igual ^ menor) & ~(mayor & igual & menor);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      estado    <= REPOSO;
      propuesta <= '0;
      resultado <= '0;
      ocupado   <= 1'b0;
      listo     <= 1'b0;
      error     <= 1'b0;
      idx       <= '0;
    end else begin
      unique case (estado)
        REPOSO: begin
          listo <= 1'b0;
          if (inicio) begin
            estado    <= EVALUAR;
            propuesta <= {1'b1, {(N-1){1'b0}}};
            idx       <= W_IDX'(N - 1);
            error     <= 1'b0;
            ocupado   <= 1'b1;
          end
        end
        EVALUAR: begin
          if (!flags_ok) begin
            estado    <= REPOSO;
            propuesta <= '0;
            error     <= 1'b1;
            ocupado   <= 1'b0;
          end else if (igual) begin
            estado    <= FIN;
            resultado <= propuesta;
            ocupado   <= 1'b0;
            listo     <= 1'b1;
          end else if (idx == '0) begin
            estado    <= FIN;
            resultado <= cand;
            ocupado   <= 1'b0;
            listo     <= 1'b1;
          end else begin
            idx       <= idx - 1'b1;
            propuesta <= cand | bit_sig;
          end
        end
        FIN: begin
          estado  <= REPOSO;
          listo   <= 1'b0;
          ocupado <= 1'b0;
        end
        default: begin
          estado  <= REPOSO;
          listo   <= 1'b0;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buscador_sar.sv
// Self-checking bench for buscador_sar: behavioural comparator plus a
// cycle-level reference model derived from the binary-search rules.
module tb_buscador_sar;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          inicio;
  logic          mayor, igual, menor;
  logic [NB-1:0] propuesta;
  logic          ocupado;
  logic          listo;
  logic [NB-1:0] resultado;
  logic          error;

  logic [NB-1:0] objetivo;
  int            fault_at;
  int            fault_kind;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  logic [NB-1:0] seen [0:15];

  // reference model state
  logic          m_act, m_fin, m_err;
  int            m_j, m_k, m_fault;
  logic [NB-1:0] m_obj, m_prop, m_res;

  buscador_sar #(.N(NB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .inicio    (inicio),
    .mayor     (mayor),
    .igual     (igual),
    .menor     (menor),
    .propuesta (propuesta),
    .ocupado   (ocupado),
    .listo     (listo),
    .resultado (resultado),
    .error     (error)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] comparador_n(input logic [NB-1:0] obj,
                                              input logic [NB-1:0] prop);
    return {obj > prop, obj == prop, obj < prop};
  endfunction

  // Candidate shown at evaluation j: known upper j-1 bits of obj plus trial bit.
  function automatic logic [NB-1:0] prop_at(input logic [NB-1:0] o, input int j);
    int s;
    logic [NB-1:0] hi;
    logic [NB-1:0] one;
    s   = NB - j + 1;
    hi  = (s >= NB) ? '0 : ((o >> s) << s);
    one = 1;
    return hi | (one << (NB - j));
  endfunction

  // Evaluations needed: igual fires once the lowest set bit is tried.
  function automatic int evals(input logic [NB-1:0] o);
    if (o == 0) return NB;
    for (int i = 0; i < NB; i++)
      if (o[i]) return NB - i;
    return NB;
  endfunction

  always_comb begin
    {mayor, igual, menor} = comparador_n(objetivo, propuesta);
    if (m_act && m_j == m_fault) begin
      if (fault_kind == 1) {mayor, igual, menor} = 3'b101;
      else                 {mayor, igual, menor} = 3'b000;
    end
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      m_act <= 1'b0; m_fin <= 1'b0; m_err <= 1'b0;
      m_j <= 0; m_k <= 0; m_fault <= 0;
      m_prop <= '0; m_res <= '0; m_obj <= '0;
    end else if (m_fin) begin
      m_fin <= 1'b0;
    end else if (m_act) begin
      if (m_j == m_fault) begin
        m_act <= 1'b0; m_err <= 1'b1; m_prop <= '0;
      end else if (m_j == m_k) begin
        m_act <= 1'b0; m_fin <= 1'b1; m_res <= m_obj;
        m_prop <= prop_at(m_obj, m_k);
      end else begin
        m_j <= m_j + 1;
      end
    end else if (inicio) begin
      m_act <= 1'b1; m_j <= 1; m_err <= 1'b0;
      m_obj <= objetivo; m_k <= evals(objetivo); m_fault <= fault_at;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("propuesta", propuesta, m_act ? prop_at(m_obj, m_j) : m_prop);
      check("ocupado", ocupado, m_act);
      check("listo", listo, m_fin);
      check("resultado", resultado, m_res);
      check("error", error, m_err);
    end
  end

  task automatic run(input logic [NB-1:0] obj, input int fat, input int kind,
                     input bit hold, output int lat, output int nl);
    @(negedge clk);
    #2;
    objetivo = obj; fault_at = fat; fault_kind = kind; inicio = 1'b1;
    @(posedge clk);
    #2;
    if (!hold) inicio = 1'b0;
    lat = 0; nl = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      seen[c] = propuesta;
      if (listo) begin
        nl++;
        if (lat == 0) lat = c;
        if (hold) begin #2; inicio = 1'b0; end
      end
    end
    inicio = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, nl, k, f, kind;
    logic [NB-1:0] o;
    logic [NB-1:0] exp5a [1:7];
    exp5a[1] = 8'h80; exp5a[2] = 8'h40; exp5a[3] = 8'h60; exp5a[4] = 8'h50;
    exp5a[5] = 8'h58; exp5a[6] = 8'h5C; exp5a[7] = 8'h5A;

    reset_n = 1'b0; inicio = 1'b0; objetivo = '0; fault_at = 0; fault_kind = 0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_propuesta", propuesta, 0);
    check("reset_listo", listo, 0);
    #2 reset_n = 1'b1;

    run(8'h5A, 0, 0, 0, lat, nl);
    check("5a_latency", lat, 8);
    check("5a_pulses", nl, 1);
    check("5a_resultado", resultado, 8'h5A);
    check("5a_error", error, 0);
    for (int i = 1; i <= 7; i++) check("5a_sequence", seen[i], exp5a[i]);

    run(8'h00, 0, 0, 0, lat, nl);
    check("00_latency", lat, 9);
    check("00_resultado", resultado, 8'h00);
    check("00_last_prop", propuesta, 8'h01);

    run(8'hFF, 0, 0, 0, lat, nl);
    check("ff_latency", lat, 9);
    check("ff_resultado", resultado, 8'hFF);
    check("ff_seq2", seen[2], 8'hC0);
    check("ff_seq8", seen[8], 8'hFF);

    for (int kd = 1; kd <= 2; kd++) begin
      run(8'h5A, 3, kd, 0, lat, nl);
      check("fault_pulses", nl, 0);
      check("fault_error", error, 1);
      check("fault_propuesta", propuesta, 0);
      check("fault_ocupado", ocupado, 0);
      run(8'h5A, 0, 0, 0, lat, nl);
      check("fault_clear", error, 0);
      check("fault_recover", resultado, 8'h5A);
    end

    run(8'h5A, 0, 0, 1, lat, nl);
    check("hold_pulses", nl, 1);
    check("hold_latency", lat, 8);
    check("hold_resultado", resultado, 8'h5A);

    // reset sampled at the edge of evaluation 4
    @(negedge clk);
    #2 objetivo = 8'h5A; fault_at = 0; inicio = 1'b1;
    @(posedge clk);
    #2 inicio = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    check("rst_propuesta", propuesta, 0);
    check("rst_resultado", resultado, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_listo", listo, 0);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run(8'h33, 0, 0, 0, lat, nl);
    check("33_latency", lat, 9);
    check("33_resultado", resultado, 8'h33);

    for (int t = 0; t < 40; t++) begin
      o = 8'($urandom_range(0, 255));
      k = evals(o);
      f = 0; kind = 0;
      if ($urandom_range(0, 3) == 0) begin
        f = $urandom_range(1, k);
        kind = $urandom_range(1, 2);
      end
      run(o, f, kind, (f == 0) && ($urandom_range(0, 3) == 0), lat, nl);
      if (f == 0) begin
        check("rnd_latency", lat, k + 1);
        check("rnd_resultado", resultado, o);
      end else begin
        check("rnd_fault_pulses", nl, 0);
        check("rnd_fault_error", error, 1);
      end
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
